sram_port_responder: RTL and testbench

- Memory-side responder for the two-port command/tag SRAM interface driven by the image filter initiators: port 0 is read (query/tag return), port 1 is write.
- Backs both ports with one internal word-addressed RAM. Provides ready handshakes and a fixed-latency tagged read pipeline.
- Used as the on-chip SRAM model and as the bench target for filter blocks.

---
 rtl/sram_port_responder_if.sv | 37 +++
 rtl/sram_port_responder.sv | 160 ++++++++++++++++
 tb/tb_sram_port_responder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_responder_if.sv
// Command/tag SRAM bus between an image-filter initiator and the responder:
// port 0 carries tagged reads, port 1 carries writes.
interface sram_port_responder_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int TAG_WIDTH     = 4
);
    logic                     request0;
    logic                     command_entry0;
    logic [ADDRESS_WIDTH-1:0] address0;
    logic [TAG_WIDTH-1:0]     tag0;
    logic                     ready0;
    logic                     valid0;
    logic [DATA_WIDTH-1:0]    query0;
    logic [TAG_WIDTH-1:0]     qtag0;

    logic                     request1;
    logic                     command_entry1;
    logic                     write_enable1;
    logic [ADDRESS_WIDTH-1:0] address1;
    logic [DATA_WIDTH-1:0]    data_in1;
    logic                     ready1;

    logic                     err_addr;

    modport master (
        output request0, command_entry0, address0, tag0,
        output request1, command_entry1, write_enable1, address1, data_in1,
        input  ready0, valid0, query0, qtag0, ready1, err_addr
    );

    modport slave (
        input  request0, command_entry0, address0, tag0,
        input  request1, command_entry1, write_enable1, address1, data_in1,
        output ready0, valid0, query0, qtag0, ready1, err_addr
    );
endinterface

// File: rtl/sram_port_responder.sv
// Two-port SRAM responder: session FSMs per port, one word-addressed RAM and
// a fixed-latency tagged read pipeline.
module sram_port_responder #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TAG_WIDTH      = 4,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int READ_LATENCY   = 3
) (
    input logic clock,
    input logic reset,
    sram_port_responder_if.slave bus
);
    localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
    // Output register holds one more read than the pipeline stages.
    localparam int CNT_W     = $clog2(READ_LATENCY + 2);

    typedef enum logic [1:0] {
        S0_IDLE   = 2'd0,
        S0_ACTIVE = 2'd1,
        S0_DRAIN  = 2'd2
    } state0_t;

    typedef enum logic {
        S1_IDLE   = 1'b0,
        S1_ACTIVE = 1'b1
    } state1_t;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } rd_resp_t;

    state0_t                   state0, next0;
    state1_t                   state1, next1;
    logic                      ready0_q, ready1_q, err_q;
    logic [CNT_W-1:0]          inflight;
    logic [READ_LATENCY:0]     vld_pipe;
    rd_resp_t                  resp_pipe [0:READ_LATENCY];
    logic [DATA_WIDTH-1:0]     mem [0:MEM_DEPTH-1];
    logic                      oor0, oor1;
    logic [MEM_DEPTH_LOG2-1:0] idx0, idx1;
    logic                      accept0, commit1;

    generate
        if (ADDRESS_WIDTH > MEM_DEPTH_LOG2) begin : g_decode
            assign oor0 = |bus.address0[ADDRESS_WIDTH-1:MEM_DEPTH_LOG2];
            assign oor1 = |bus.address1[ADDRESS_WIDTH-1:MEM_DEPTH_LOG2];
            assign idx0 = bus.address0[MEM_DEPTH_LOG2-1:0];
            assign idx1 = bus.address1[MEM_DEPTH_LOG2-1:0];
        end else begin : g_nodecode
            assign oor0 = 1'b0;
            assign oor1 = 1'b0;
            assign idx0 = MEM_DEPTH_LOG2'(bus.address0);
            assign idx1 = MEM_DEPTH_LOG2'(bus.address1);
        end
    endgenerate

    assign accept0 = bus.command_entry0 && (state0 == S0_ACTIVE);
    assign commit1 = bus.command_entry1 && bus.write_enable1 && (state1 == S1_ACTIVE);

    // Port 0 session FSM
    always_comb begin
        next0 = state0;
        unique case (state0)
            S0_IDLE:   if (bus.request0) next0 = S0_ACTIVE;
            S0_ACTIVE: if (!bus.request0) next0 = S0_DRAIN;
            S0_DRAIN: begin
                if (bus.request0)       next0 = S0_ACTIVE;
                else if (inflight == '0) next0 = S0_IDLE;
            end
            default:   next0 = S0_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state0   <= S0_IDLE;
            ready0_q <= 1'b0;
        end else begin
            state0   <= next0;
            ready0_q <= (next0 == S0_ACTIVE);
        end
    end

    // Port 1 session FSM
    always_comb begin
        next1 = state1;
        unique case (state1)
            S1_IDLE:   if (bus.request1) next1 = S1_ACTIVE;
            S1_ACTIVE: if (!bus.request1) next1 = S1_IDLE;
            default:   next1 = S1_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state1   <= S1_IDLE;
            ready1_q <= 1'b0;
        end else begin
            state1   <= next1;
            ready1_q <= (next1 == S1_ACTIVE);
        end
    end

    // RAM contents survive reset; out-of-range writes never land.
    always_ff @(posedge clock) begin
        if (commit1 && !oor1)
            mem[idx1] <= bus.data_in1;
    end

    // Stage 0 samples the RAM before this edge's write lands, giving
    // read-first behaviour. Payload stages only load behind a valid so the
    // last stage holds the previous response when idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            for (int i = 0; i <= READ_LATENCY; i++)
                resp_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= accept0;
            if (accept0) begin
                resp_pipe[0].tag  <= bus.tag0;
                resp_pipe[0].data <= oor0 ? '0 : mem[idx0];
            end
            for (int i = 1; i <= READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1])
                    resp_pipe[i] <= resp_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            case ({accept0, vld_pipe[READ_LATENCY]})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else if ((accept0 && oor0) || (commit1 && oor1))
            err_q <= 1'b1;
    end

    assign bus.ready0   = ready0_q;
    assign bus.ready1   = ready1_q;
    assign bus.valid0   = vld_pipe[READ_LATENCY];
    assign bus.query0   = resp_pipe[READ_LATENCY].data;
    assign bus.qtag0    = resp_pipe[READ_LATENCY].tag;
    assign bus.err_addr = err_q;

endmodule

// File: tb/tb_sram_port_responder.sv
// Directed bench for sram_port_responder: a cycle table for the fill/readback
// burst plus hand sequences for drain, read-first, range errors and reset.
module tb_sram_port_responder;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int ML = 10;
    localparam int RL = 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sram_port_responder_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    sram_port_responder #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
        .MEM_DEPTH_LOG2(ML), .READ_LATENCY(RL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic          req0, ce0;
        logic [AW-1:0] addr0;
        logic [TW-1:0] tag0;
        logic          req1, ce1, we1;
        logic [AW-1:0] addr1;
        logic [DW-1:0] din1;
        logic          rdy0, rdy1, vld, err;
        logic [DW-1:0] q;
        logic [TW-1:0] qt;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic r0, input logic c0, input logic [AW-1:0] a0,
                         input logic [TW-1:0] t0, input logic r1, input logic c1,
                         input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        bus.request0       = r0;
        bus.command_entry0 = c0;
        bus.address0       = a0;
        bus.tag0           = t0;
        bus.request1       = r1;
        bus.command_entry1 = c1;
        bus.write_enable1  = w1;
        bus.address1       = a1;
        bus.data_in1       = d1;
    endtask

    task automatic push(input logic r0, input logic c0, input logic [AW-1:0] a0,
                        input logic [TW-1:0] t0, input logic r1, input logic c1,
                        input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        vec_t v;
        v.req0 = r0; v.ce0 = c0; v.addr0 = a0; v.tag0 = t0;
        v.req1 = r1; v.ce1 = c1; v.we1 = w1; v.addr1 = a1; v.din1 = d1;
        v.rdy0 = r0; v.rdy1 = r1; v.vld = 1'b0; v.err = 1'b0;
        v.q = '0; v.qt = '0;
        tbl.push_back(v);
    endtask

    function automatic logic [TW-1:0] rd_tag(input int i);
        return (i < 15) ? TW'(i + 1) : TW'(1);
    endfunction

    initial begin
        logic [DW-1:0] last_q;
        logic [TW-1:0] last_qt;
        logic [DW-1:0] word;
        bit            seen;

        drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
        reset = 1'b1;
        tick();
        tick();
        chk("reset.ready0",   64'(bus.ready0),   64'(0));
        chk("reset.ready1",   64'(bus.ready1),   64'(0));
        chk("reset.valid0",   64'(bus.valid0),   64'(0));
        chk("reset.query0",   64'(bus.query0),   64'(0));
        chk("reset.qtag0",    64'(bus.qtag0),    64'(0));
        chk("reset.err_addr", 64'(bus.err_addr), 64'(0));
        reset = 1'b0;

        // Fill 0..15, read them back-to-back, drain the pipeline.
        push(1, 0, '0, '0, 1, 0, 0, '0, '0);
        for (int i = 0; i < 16; i++) begin
            word = 32'hA5A5_0000 + 32'(i);
            push(1, 0, '0, '0, 1, 1, 1, AW'(i), word);
        end
        for (int i = 0; i < 16; i++)
            push(1, 1, AW'(i), rd_tag(i), 1, 0, 0, '0, '0);
        for (int i = 0; i < RL; i++)
            push(1, 0, '0, '0, 1, 0, 0, '0, '0);
        // Read i is accepted on row 17+i and returns after row 17+i+RL.
        for (int i = 0; i < 16; i++) begin
            tbl[17 + i + RL].vld = 1'b1;
            tbl[17 + i + RL].q   = 32'hA5A5_0000 + 32'(i);
            tbl[17 + i + RL].qt  = rd_tag(i);
        end
        last_q  = '0;
        last_qt = '0;
        foreach (tbl[r]) begin
            if (!tbl[r].vld) begin
                tbl[r].q  = last_q;
                tbl[r].qt = last_qt;
            end else begin
                last_q  = tbl[r].q;
                last_qt = tbl[r].qt;
            end
        end

        foreach (tbl[r]) begin
            drive(tbl[r].req0, tbl[r].ce0, tbl[r].addr0, tbl[r].tag0, tbl[r].req1,
                  tbl[r].ce1, tbl[r].we1, tbl[r].addr1, tbl[r].din1);
            tick();
            chk($sformatf("tbl[%0d].ready0", r),   64'(bus.ready0),   64'(tbl[r].rdy0));
            chk($sformatf("tbl[%0d].ready1", r),   64'(bus.ready1),   64'(tbl[r].rdy1));
            chk($sformatf("tbl[%0d].valid0", r),   64'(bus.valid0),   64'(tbl[r].vld));
            chk($sformatf("tbl[%0d].query0", r),   64'(bus.query0),   64'(tbl[r].q));
            chk($sformatf("tbl[%0d].qtag0", r),    64'(bus.qtag0),    64'(tbl[r].qt));
            chk($sformatf("tbl[%0d].err_addr", r), 64'(bus.err_addr), 64'(tbl[r].err));
        end

        // Drain: command at edge 2, request0 dropped at edge 3.
        drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1, 0, '0, '0, 0, 0, 0, '0, '0);
        tick();
        chk("drain.ready0_e0", 64'(bus.ready0), 64'(1));
        tick();
        drive(1, 1, AW'(5), TW'(4), 0, 0, 0, '0, '0);
        tick();
        chk("drain.ready0_e2", 64'(bus.ready0), 64'(1));
        drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
        tick();
        chk("drain.ready0_e3", 64'(bus.ready0), 64'(0));
        chk("drain.state_e3",  64'(dut.state0), 64'(2));
        tick();
        chk("drain.valid0_e4", 64'(bus.valid0), 64'(0));
        tick();
        chk("drain.valid0_e5", 64'(bus.valid0), 64'(1));
        chk("drain.query0_e5", 64'(bus.query0), 64'(32'hA5A5_0005));
        chk("drain.qtag0_e5",  64'(bus.qtag0),  64'(4));
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            if (dut.state0 == 2'd0) seen = 1'b1;
            else tick();
        end
        chk("drain.reached_idle", 64'(seen),      64'(1));
        chk("drain.ready0_idle",  64'(bus.ready0), 64'(0));

        // Same-edge read and write of address 7: old word first, new word next.
        drive(1, 0, '0, '0, 1, 0, 0, '0, '0);
        tick();
        drive(1, 0, '0, '0, 1, 1, 1, AW'(7), DW'(32'h11));
        tick();
        drive(1, 1, AW'(7), TW'(0), 1, 1, 1, AW'(7), DW'(32'h22));
        tick();
        drive(1, 1, AW'(7), TW'(3), 1, 0, 0, '0, '0);
        tick();
        drive(1, 0, '0, '0, 1, 0, 0, '0, '0);
        tick();
        chk("rw7.valid0_early", 64'(bus.valid0), 64'(0));
        tick();
        chk("rw7.valid0_old", 64'(bus.valid0), 64'(1));
        chk("rw7.query0_old", 64'(bus.query0), 64'(32'h11));
        chk("rw7.qtag0_old",  64'(bus.qtag0),  64'(0));
        tick();
        chk("rw7.valid0_new", 64'(bus.valid0), 64'(1));
        chk("rw7.query0_new", 64'(bus.query0), 64'(32'h22));
        chk("rw7.qtag0_new",  64'(bus.qtag0),  64'(3));
        tick();
        chk("rw7.valid0_idle", 64'(bus.valid0), 64'(0));
        chk("rw7.query0_hold", 64'(bus.query0), 64'(32'h22));
        chk("rw7.qtag0_hold",  64'(bus.qtag0),  64'(3));

        // Out-of-range read and write at 0x400; index 0 must be untouched.
        drive(1, 0, '0, '0, 1, 1, 1, AW'(0), DW'(32'h55));
        tick();
        drive(1, 0, '0, '0, 1, 0, 0, '0, '0);
        chk("oor.err_before", 64'(bus.err_addr), 64'(0));
        drive(1, 1, AW'(32'h400), TW'(9), 1, 0, 0, '0, '0);
        tick();
        chk("oor.err_set", 64'(bus.err_addr), 64'(1));
        drive(1, 0, '0, '0, 1, 1, 1, AW'(32'h400), DW'(32'h77));
        tick();
        drive(1, 0, '0, '0, 1, 0, 0, '0, '0);
        tick();
        chk("oor.valid0_early", 64'(bus.valid0), 64'(0));
        tick();
        chk("oor.valid0", 64'(bus.valid0), 64'(1));
        chk("oor.query0", 64'(bus.query0), 64'(0));
        chk("oor.qtag0",  64'(bus.qtag0),  64'(9));
        drive(1, 1, AW'(0), TW'(1), 1, 0, 0, '0, '0);
        tick();
        drive(1, 0, '0, '0, 1, 0, 0, '0, '0);
        tick();
        tick();
        tick();
        chk("oor.valid0_addr0", 64'(bus.valid0),   64'(1));
        chk("oor.query0_addr0", 64'(bus.query0),   64'(32'h55));
        chk("oor.err_held",     64'(bus.err_addr), 64'(1));

        // Reset with three reads in flight: immediate clear, no stale valid0.
        for (int i = 1; i <= 3; i++) begin
            drive(1, 1, AW'(i), TW'(i), 1, 0, 0, '0, '0);
            tick();
        end
        drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
        reset = 1'b1;
        #1;
        chk("rst.valid0_async", 64'(bus.valid0),   64'(0));
        chk("rst.ready0_async", 64'(bus.ready0),   64'(0));
        chk("rst.ready1_async", 64'(bus.ready1),   64'(0));
        chk("rst.err_async",    64'(bus.err_addr), 64'(0));
        chk("rst.query0_async", 64'(bus.query0),   64'(0));
        chk("rst.qtag0_async",  64'(bus.qtag0),    64'(0));
        tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (bus.valid0 || bus.ready0) seen = 1'b1;
        end
        chk("rst.no_stale_activity", 64'(seen),      64'(0));
        chk("rst.state_idle",        64'(dut.state0), 64'(0));
        drive(1, 0, '0, '0, 0, 0, 0, '0, '0);
        tick();
        chk("rst.ready0_resample", 64'(bus.ready0), 64'(1));

        // command_entry1 without write_enable1 must not write.
        drive(1, 0, '0, '0, 1, 0, 0, '0, '0);
        tick();
        drive(1, 0, '0, '0, 1, 1, 0, AW'(3), DW'(32'hDEAD_BEEF));
        tick();
        drive(1, 1, AW'(3), TW'(6), 1, 0, 0, '0, '0);
        tick();
        drive(1, 0, '0, '0, 1, 0, 0, '0, '0);
        tick();
        tick();
        tick();
        chk("nowe.valid0", 64'(bus.valid0),   64'(1));
        chk("nowe.query0", 64'(bus.query0),   64'(32'hA5A5_0003));
        chk("nowe.qtag0",  64'(bus.qtag0),    64'(6));
        chk("nowe.err",    64'(bus.err_addr), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
